// File: rtl/neural_soc_sysid_pkg.sv
// Shared definitions for the system-ID boot checker.
// Contents: the FSM state encoding, the sysid slave word addresses, the data
// width, and the word comparison used to qualify the captured words.
package neural_soc_sysid_pkg;

  localparam int   SYSID_DATA_W  = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // WT_* states are only reachable when the slave reports data with readdatavalid.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_WT_ID = 3'd2,
    ST_RD_TS = 3'd3,
    ST_WT_TS = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } sysid_state_e;

  // Full-width equality between a captured word and its expected value.
  function automatic logic word_match(input logic [SYSID_DATA_W-1:0] got,
                                      input logic [SYSID_DATA_W-1:0] expected);
    return (got == expected);
  endfunction

endpackage

// File: rtl/neural_soc_sysid_reader_if.sv
// Avalon-MM read-only bus between the boot checker (master) and the
// system-ID slave.
// Signals: avm_address (word select), avm_read (read strobe),
// avm_waitrequest (slave stall), avm_readdata (32-bit data),
// avm_readdatavalid (data strobe for pipelined slaves).
interface neural_soc_sysid_reader_if;
  import neural_soc_sysid_pkg::*;

  logic                    avm_address;
  logic                    avm_read;
  logic                    avm_waitrequest;
  logic [SYSID_DATA_W-1:0] avm_readdata;
  logic                    avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/neural_soc_sysid_timeout_ctr.sv
// Per-read watchdog for the system-ID checker.
// Ports: clock, reset (sync, active high), clear (restart count, wins over
// enable), enable (count this cycle), expired (count has reached
// TIMEOUT_CYCLES while enabled).
module neural_soc_sysid_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: clear has priority; saturate so a huge stall cannot wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 16'd0;
    end else if (enable && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && ({16'd0, count_q} >= TIMEOUT_CYCLES);

endmodule

// File: rtl/neural_soc_sysid_reader.sv
// Boot-time system-ID checker: reads word 0 (ID) and word 1 (build timestamp)
// from the sysid slave and compares them with the expected build.
// Ports: clock, reset (sync, active high), start (sampled in IDLE/DONE),
// avm (Avalon-MM master), busy, done (1-cycle pulse), id_value,
// timestamp_value (captured words), id_match, ts_match, timeout_err.
module neural_soc_sysid_reader
  import neural_soc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480283514,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          USE_READDATAVALID  = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  neural_soc_sysid_reader_if.master avm,
  output logic                      busy,
  output logic                      done,
  output logic [SYSID_DATA_W-1:0]   id_value,
  output logic [SYSID_DATA_W-1:0]   timestamp_value,
  output logic                      id_match,
  output logic                      ts_match,
  output logic                      timeout_err
);

  sysid_state_e            state_q, state_d;
  logic                    read_q, read_d;
  logic                    addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [SYSID_DATA_W-1:0] id_value_q, id_value_d;
  logic [SYSID_DATA_W-1:0] ts_value_q, ts_value_d;
  logic                    id_match_q, id_match_d;
  logic                    ts_match_q, ts_match_d;
  logic                    timeout_err_q, timeout_err_d;

  logic accept_s;
  logic capture_s;
  logic abort_s;
  logic ts_phase_s;
  logic ctr_clear_s;
  logic ctr_en_s;
  logic expired_s;

  neural_soc_sysid_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock  (clock),
    .reset  (reset),
    .clear  (ctr_clear_s),
    .enable (ctr_en_s),
    .expired(expired_s)
  );

  assign accept_s   = read_q && !avm.avm_waitrequest;
  assign ts_phase_s = (state_q == ST_RD_TS) || (state_q == ST_WT_TS);

  // Next-state and output computation. Each RD state spends its first cycle
  // with avm_read low, which provides the required gap between the two reads.
  always_comb begin
    state_d       = state_q;
    read_d        = read_q;
    addr_d        = addr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    id_match_d    = id_match_q;
    ts_match_d    = ts_match_q;
    timeout_err_d = timeout_err_q;
    ctr_clear_s   = 1'b0;
    ctr_en_s      = 1'b0;
    capture_s     = 1'b0;
    abort_s       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_RD_ID;
          addr_d        = SYSID_ADDR_ID;
          busy_d        = 1'b1;
          id_value_d    = '0;
          ts_value_d    = '0;
          id_match_d    = 1'b0;
          ts_match_d    = 1'b0;
          timeout_err_d = 1'b0;
          ctr_clear_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        ctr_en_s = 1'b1;
        if (accept_s) begin
          read_d = 1'b0;
          // A readdatavalid coinciding with the accept cycle is taken directly.
          if (!USE_READDATAVALID || avm.avm_readdatavalid) begin
            capture_s = 1'b1;
          end else begin
            state_d = (state_q == ST_RD_ID) ? ST_WT_ID : ST_WT_TS;
          end
        end else if (expired_s) begin
          abort_s = 1'b1;
        end else begin
          // Hold the strobe (and address) steady until the slave accepts.
          read_d = 1'b1;
        end
      end
      ST_WT_ID, ST_WT_TS: begin
        ctr_en_s = 1'b1;
        if (avm.avm_readdatavalid) begin
          capture_s = 1'b1;
        end else if (expired_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_CHECK: begin
        id_match_d = word_match(id_value_q, EXPECTED_ID);
        ts_match_d = word_match(ts_value_q, EXPECTED_TIMESTAMP);
        state_d    = ST_DONE;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (capture_s) begin
      if (ts_phase_s) begin
        ts_value_d = avm.avm_readdata;
        state_d    = ST_CHECK;
      end else begin
        id_value_d  = avm.avm_readdata;
        state_d     = ST_RD_TS;
        addr_d      = SYSID_ADDR_TS;
        ctr_clear_s = 1'b1;
      end
    end else if (abort_s) begin
      // Abandon the check; any data arriving later is ignored in DONE.
      read_d        = 1'b0;
      timeout_err_d = 1'b1;
      id_match_d    = 1'b0;
      ts_match_d    = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b1;
      state_d       = ST_DONE;
    end else begin
      done_d = done_d;
    end
  end

  // State, bus strobe, captures and result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      read_q        <= 1'b0;
      addr_q        <= SYSID_ADDR_ID;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_q        <= read_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      id_match_q    <= id_match_d;
      ts_match_q    <= ts_match_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_value        = id_value_q;
  assign timestamp_value = ts_value_q;
  assign id_match        = id_match_q;
  assign ts_match        = ts_match_q;
  assign timeout_err     = timeout_err_q;

endmodule
